vga_fb_scanout: RTL



---
 rtl/vga_fb_scanout.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vga_fb_scanout.sv
// Frame-buffer scan-out: 640x480@60 timing from a 320x240 RGB332 buffer read
// through port B of the VGA RAM, with a small prefetch FIFO and 2x2 pixel doubling.
module vga_fb_scanout #(
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned H_FP           = 16,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_BP           = 48,
  parameter int unsigned V_ACTIVE       = 480,
  parameter int unsigned V_FP           = 10,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BP           = 33,
  parameter int unsigned PIX_DIV        = 2,
  parameter int unsigned WORDS_PER_LINE = 40,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [14:0] fb_base,
  output logic        rd_req,
  input  logic        rd_gnt,
  output logic [14:0] rd_addr,
  input  logic [63:0] rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  rgb,
  output logic        frame_start,
  output logic        underflow
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SS    = H_ACTIVE + H_FP;
  localparam int unsigned V_SS    = V_ACTIVE + V_FP;
  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = PW + 1;
  localparam int unsigned DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned WW      = $clog2(WORDS_PER_LINE + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} fetch_e;

  fetch_e          state_q;
  logic [DW-1:0]   div_q;
  logic [9:0]      h_q, v_q;
  logic [14:0]     base_q, addr_q;
  logic [WW-1:0]   w_q;
  logic            infl_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     fifo_q [FIFO_DEPTH];
  logic            hsync_q, vsync_q, de_q, fs_q, unf_q;
  logic [7:0]      rgb_q;

  logic        tick, h_wrap, v_wrap, de_req, hs_act, vs_act;
  logic [9:0]  next_line;
  logic        next_vis, start, flush, grant, push, pop, empty, room;
  logic [14:0] row, line_addr;
  logic [63:0] head;
  logic [5:0]  boff;
  logic [7:0]  pix;

  assign tick   = en && (div_q == DW'(PIX_DIV - 1));
  assign h_wrap = (h_q == 10'(H_TOTAL - 1));
  assign v_wrap = (v_q == 10'(V_TOTAL - 1));
  assign de_req = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
  assign hs_act = (h_q >= 10'(H_SS)) && (h_q < 10'(H_SS + H_SYNC));
  assign vs_act = (v_q >= 10'(V_SS)) && (v_q < 10'(V_SS + V_SYNC));

  // Fetch during hblank of line v is for the line displayed next.
  assign next_line = v_wrap ? '0 : v_q + 10'd1;
  assign next_vis  = (next_line < 10'(V_ACTIVE));
  assign row       = 15'(next_line >> 1);
  assign line_addr = base_q + row * 15'(WORDS_PER_LINE);

  assign start = tick && (h_q == 10'(H_ACTIVE));
  assign flush = start && (state_q != FETCH);
  assign empty = (cnt_q == '0);
  assign room  = ({1'b0, cnt_q} + (CW+1)'(infl_q)) < (CW+1)'(FIFO_DEPTH);
  assign grant = rd_req && rd_gnt;
  assign push  = infl_q && !flush;
  assign pop   = tick && de_req && (h_q[3:0] == 4'hF) && !empty;

  assign head = fifo_q[rd_ptr_q];
  assign boff = {h_q[3:1], 3'b000};
  assign pix  = head[boff +: 8];

  assign rd_req      = en && (state_q == FETCH) && room;
  assign rd_addr     = addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;
  assign underflow   = unf_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else if (!en) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + DW'(1);
      if (tick) begin
        if (h_wrap) begin
          h_q <= '0;
          v_q <= v_wrap ? '0 : v_q + 10'd1;
        end else begin
          h_q <= h_q + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        base_q <= '0;
    else if (h_q == '0 && v_q == '0)   base_q <= fb_base;
  end

  // A fetch still stalled at the next hblank keeps running rather than restarting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;  w_q <= '0;  addr_q <= '0;  infl_q <= 1'b0;
      wr_ptr_q <= '0;   rd_ptr_q <= '0;  cnt_q <= '0;
    end else if (!en) begin
      state_q <= IDLE;  w_q <= '0;  addr_q <= '0;  infl_q <= 1'b0;
      wr_ptr_q <= '0;   rd_ptr_q <= '0;  cnt_q <= '0;
    end else begin
      infl_q <= grant;
      if (flush) begin
        state_q  <= next_vis ? FETCH : IDLE;
        addr_q   <= next_vis ? line_addr : '0;
        w_q      <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        cnt_q <= cnt_d;
        if (grant) begin
          if (w_q == WW'(WORDS_PER_LINE - 1)) begin
            state_q <= DONE;
            w_q     <= '0;
            addr_q  <= '0;
          end else begin
            w_q     <= w_q + WW'(1);
            addr_q  <= addr_q + 15'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= 1'b1;  vsync_q <= 1'b1;  de_q <= 1'b0;
      rgb_q   <= '0;    fs_q    <= 1'b0;  unf_q <= 1'b0;
    end else if (!en) begin
      hsync_q <= 1'b1;  vsync_q <= 1'b1;  de_q <= 1'b0;
      rgb_q   <= '0;    fs_q    <= 1'b0;  unf_q <= 1'b0;
    end else begin
      hsync_q <= !hs_act;
      vsync_q <= !vs_act;
      de_q    <= de_req;
      rgb_q   <= (de_req && !empty) ? pix : '0;
      fs_q    <= (h_q == '0) && (v_q == '0) && (div_q == '0);
      if (de_req && empty) unf_q <= 1'b1;
    end
  end
endmodule
